// File: rtl/lvt_write_arbiter.sv
// Four-port write arbiter for a 3-bank LVT multiported memory: ports 0/1 share bank 0,
// port 2 owns bank 1 and port 3 owns bank 2. Optional stall counters via LVT_ARB_PERF_EN.
module lvt_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_req_0,
    input  logic              wr_req_1,
    input  logic              wr_req_2,
    input  logic              wr_req_3,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [ADDR_W-1:0] wr_addr_2,
    input  logic [ADDR_W-1:0] wr_addr_3,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic [DATA_W-1:0] wr_data_1,
    input  logic [DATA_W-1:0] wr_data_2,
    input  logic [DATA_W-1:0] wr_data_3,
    output logic              wr_gnt_0,
    output logic              wr_gnt_1,
    output logic              wr_gnt_2,
    output logic              wr_gnt_3,
    output logic              bank_we_0,
    output logic              bank_we_1,
    output logic              bank_we_2,
    output logic [ADDR_W-1:0] bank_addr_0,
    output logic [ADDR_W-1:0] bank_addr_1,
    output logic [ADDR_W-1:0] bank_addr_2,
    output logic [DATA_W-1:0] bank_data_0,
    output logic [DATA_W-1:0] bank_data_1,
    output logic [DATA_W-1:0] bank_data_2,
    output logic              lvt_we_0,
    output logic              lvt_we_1,
    output logic              lvt_we_2,
    output logic [ADDR_W-1:0] lvt_addr_0,
    output logic [ADDR_W-1:0] lvt_addr_1,
    output logic [ADDR_W-1:0] lvt_addr_2,
    output logic [1:0]        lvt_val_0,
    output logic [1:0]        lvt_val_1,
    output logic [1:0]        lvt_val_2
`ifdef LVT_ARB_PERF_EN
    ,
    output logic [15:0]       stall_cnt_0,
    output logic [15:0]       stall_cnt_1,
    output logic [15:0]       stall_cnt_2,
    output logic [15:0]       stall_cnt_3
`endif
);

    logic [3:0]        w_req;
    logic [ADDR_W-1:0] w_addr [4];
    logic [DATA_W-1:0] w_data [4];
    logic [3:0]        w_gnt;
    logic [2:0]        w_bank_gnt;
    logic              w_c0_valid;
    logic              w_c0_sel;
    logic              w_c0_ok;
    logic [ADDR_W-1:0] w_c0_addr;
    logic [DATA_W-1:0] w_c0_data;

    // r_last: last bank-0 winner (0 = port 0, 1 = port 1)
    logic              r_last;
    logic [2:0]        r_we;
    logic [ADDR_W-1:0] r_addr [3];
    logic [DATA_W-1:0] r_data [3];
    logic [1:0]        r_val  [3];

    assign w_req     = {wr_req_3, wr_req_2, wr_req_1, wr_req_0};
    assign w_addr[0] = wr_addr_0;
    assign w_addr[1] = wr_addr_1;
    assign w_addr[2] = wr_addr_2;
    assign w_addr[3] = wr_addr_3;
    assign w_data[0] = wr_data_0;
    assign w_data[1] = wr_data_1;
    assign w_data[2] = wr_data_2;
    assign w_data[3] = wr_data_3;

    // Collisions are judged against requests, not grants: a blocked port 2 still
    // shadows a bank-0 candidate at the same address.
    always_comb begin
        w_gnt      = '0;
        w_c0_valid = w_req[0] | w_req[1];
        w_c0_sel   = (w_req[0] && w_req[1]) ? ~r_last : w_req[1];
        w_c0_addr  = w_c0_sel ? w_addr[1] : w_addr[0];
        w_c0_data  = w_c0_sel ? w_data[1] : w_data[0];
        w_c0_ok    = w_c0_valid
                     && !(w_req[3] && (w_addr[3] == w_c0_addr))
                     && !(w_req[2] && (w_addr[2] == w_c0_addr));
        w_gnt[3]   = w_req[3];
        w_gnt[2]   = w_req[2] && !(w_req[3] && (w_addr[3] == w_addr[2]));
        w_gnt[1]   = w_c0_ok && w_c0_sel;
        w_gnt[0]   = w_c0_ok && !w_c0_sel;
        if (!reset_n) begin
            w_gnt = '0;
        end
    end

    assign w_bank_gnt = {w_gnt[3], w_gnt[2], w_gnt[1] | w_gnt[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= 1'b1;
            r_we   <= '0;
            for (int b = 0; b < 3; b++) begin
                r_addr[b] <= '0;
                r_data[b] <= '0;
                r_val[b]  <= 2'd0;
            end
        end else begin
            r_we <= w_bank_gnt;
            if (w_bank_gnt[0]) begin
                r_last    <= w_gnt[1];
                r_addr[0] <= w_c0_addr;
                r_data[0] <= w_c0_data;
                r_val[0]  <= {1'b0, w_gnt[1]};
            end
            if (w_bank_gnt[1]) begin
                r_addr[1] <= w_addr[2];
                r_data[1] <= w_data[2];
                r_val[1]  <= 2'd2;
            end
            if (w_bank_gnt[2]) begin
                r_addr[2] <= w_addr[3];
                r_data[2] <= w_data[3];
                r_val[2]  <= 2'd3;
            end
        end
    end

    assign wr_gnt_0    = w_gnt[0];
    assign wr_gnt_1    = w_gnt[1];
    assign wr_gnt_2    = w_gnt[2];
    assign wr_gnt_3    = w_gnt[3];
    assign bank_we_0   = r_we[0];
    assign bank_we_1   = r_we[1];
    assign bank_we_2   = r_we[2];
    assign lvt_we_0    = r_we[0];
    assign lvt_we_1    = r_we[1];
    assign lvt_we_2    = r_we[2];
    assign bank_addr_0 = r_addr[0];
    assign bank_addr_1 = r_addr[1];
    assign bank_addr_2 = r_addr[2];
    assign lvt_addr_0  = r_addr[0];
    assign lvt_addr_1  = r_addr[1];
    assign lvt_addr_2  = r_addr[2];
    assign bank_data_0 = r_data[0];
    assign bank_data_1 = r_data[1];
    assign bank_data_2 = r_data[2];
    assign lvt_val_0   = r_val[0];
    assign lvt_val_1   = r_val[1];
    assign lvt_val_2   = r_val[2];

`ifdef LVT_ARB_PERF_EN
    logic [15:0] r_stall [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int n = 0; n < 4; n++) begin
                r_stall[n] <= '0;
            end
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (w_req[n] && !w_gnt[n] && (r_stall[n] != 16'hFFFF)) begin
                    r_stall[n] <= r_stall[n] + 16'd1;
                end
            end
        end
    end

    assign stall_cnt_0 = r_stall[0];
    assign stall_cnt_1 = r_stall[1];
    assign stall_cnt_2 = r_stall[2];
    assign stall_cnt_3 = r_stall[3];
`endif

endmodule

// File: tb/tb_lvt_write_arbiter.sv
// Directed self-checking bench for lvt_write_arbiter; exercises the
// LVT_ARB_PERF_EN counters only when that macro is defined.
module tb_lvt_write_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_req_0 = 1'b0, wr_req_1 = 1'b0, wr_req_2 = 1'b0, wr_req_3 = 1'b0;
    logic [ADDR_W-1:0] wr_addr_0 = '0, wr_addr_1 = '0, wr_addr_2 = '0, wr_addr_3 = '0;
    logic [DATA_W-1:0] wr_data_0 = '0, wr_data_1 = '0, wr_data_2 = '0, wr_data_3 = '0;
    logic              wr_gnt_0, wr_gnt_1, wr_gnt_2, wr_gnt_3;
    logic              bank_we_0, bank_we_1, bank_we_2;
    logic [ADDR_W-1:0] bank_addr_0, bank_addr_1, bank_addr_2;
    logic [DATA_W-1:0] bank_data_0, bank_data_1, bank_data_2;
    logic              lvt_we_0, lvt_we_1, lvt_we_2;
    logic [ADDR_W-1:0] lvt_addr_0, lvt_addr_1, lvt_addr_2;
    logic [1:0]        lvt_val_0, lvt_val_1, lvt_val_2;
`ifdef LVT_ARB_PERF_EN
    logic [15:0]       stall_cnt_0, stall_cnt_1, stall_cnt_2, stall_cnt_3;
`endif

    int n_vec = 0;
    int n_err = 0;

    lvt_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_req_0(wr_req_0), .wr_req_1(wr_req_1), .wr_req_2(wr_req_2), .wr_req_3(wr_req_3),
        .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1), .wr_addr_2(wr_addr_2), .wr_addr_3(wr_addr_3),
        .wr_data_0(wr_data_0), .wr_data_1(wr_data_1), .wr_data_2(wr_data_2), .wr_data_3(wr_data_3),
        .wr_gnt_0(wr_gnt_0), .wr_gnt_1(wr_gnt_1), .wr_gnt_2(wr_gnt_2), .wr_gnt_3(wr_gnt_3),
        .bank_we_0(bank_we_0), .bank_we_1(bank_we_1), .bank_we_2(bank_we_2),
        .bank_addr_0(bank_addr_0), .bank_addr_1(bank_addr_1), .bank_addr_2(bank_addr_2),
        .bank_data_0(bank_data_0), .bank_data_1(bank_data_1), .bank_data_2(bank_data_2),
        .lvt_we_0(lvt_we_0), .lvt_we_1(lvt_we_1), .lvt_we_2(lvt_we_2),
        .lvt_addr_0(lvt_addr_0), .lvt_addr_1(lvt_addr_1), .lvt_addr_2(lvt_addr_2),
        .lvt_val_0(lvt_val_0), .lvt_val_1(lvt_val_1), .lvt_val_2(lvt_val_2)
`ifdef LVT_ARB_PERF_EN
        ,
        .stall_cnt_0(stall_cnt_0), .stall_cnt_1(stall_cnt_1),
        .stall_cnt_2(stall_cnt_2), .stall_cnt_3(stall_cnt_3)
`endif
    );

    always #5 clk = ~clk;

    // Bank view: {bank_we, lvt_we, bank_addr, bank_data, lvt_addr, lvt_val}
    function automatic logic [53:0] b0();
        return {bank_we_0, lvt_we_0, bank_addr_0, bank_data_0, lvt_addr_0, lvt_val_0};
    endfunction
    function automatic logic [53:0] b1();
        return {bank_we_1, lvt_we_1, bank_addr_1, bank_data_1, lvt_addr_1, lvt_val_1};
    endfunction
    function automatic logic [53:0] b2();
        return {bank_we_2, lvt_we_2, bank_addr_2, bank_data_2, lvt_addr_2, lvt_val_2};
    endfunction
    function automatic logic [3:0] gnt();
        return {wr_gnt_3, wr_gnt_2, wr_gnt_1, wr_gnt_0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        case (p)
            0: begin wr_req_0 = r; wr_addr_0 = a; wr_data_0 = d; end
            1: begin wr_req_1 = r; wr_addr_1 = a; wr_data_1 = d; end
            2: begin wr_req_2 = r; wr_addr_2 = a; wr_data_2 = d; end
            default: begin wr_req_3 = r; wr_addr_3 = a; wr_data_3 = d; end
        endcase
    endtask

    task automatic idle_all();
        wr_req_0 = 1'b0;
        wr_req_1 = 1'b0;
        wr_req_2 = 1'b0;
        wr_req_3 = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_port(3, 1'b1, 9'h1AB, 32'h12345678);
        set_port(0, 1'b1, 9'h0AB, 32'h87654321);
        #2;
        n_vec++;
        if (gnt() !== 4'b0000) begin
            n_err++; $display("FAIL reset_gnt: got %b expected %b", gnt(), 4'b0000);
        end
        tick();
        tick();
        n_vec++;
        if ({b0(), b1(), b2()} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0", {b0(), b1(), b2()});
        end
        idle_all();
        reset_n = 1'b1;
    endtask

    task automatic test_single_port2();
        set_port(2, 1'b1, 9'h010, 32'hDEADBEEF);
        #1;
        n_vec++;
        if (gnt() !== 4'b0100) begin
            n_err++; $display("FAIL p2_gnt: got %b expected %b", gnt(), 4'b0100);
        end
        tick();
        n_vec++;
        if (b1() !== {1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 9'h010, 2'd2}) begin
            n_err++; $display("FAIL p2_bank1: got %h expected %h", b1(),
                              {1'b1, 1'b1, 9'h010, 32'hDEADBEEF, 9'h010, 2'd2});
        end
        set_port(2, 1'b0, 9'h1F0, 32'h0BADF00D);
        #1;
        n_vec++;
        if (gnt() !== 4'b0000) begin
            n_err++; $display("FAIL p2_idle_gnt: got %b expected %b", gnt(), 4'b0000);
        end
        tick();
        n_vec++;
        if (b1() !== {1'b0, 1'b0, 9'h010, 32'hDEADBEEF, 9'h010, 2'd2}) begin
            n_err++; $display("FAIL p2_hold: got %h expected %h", b1(),
                              {1'b0, 1'b0, 9'h010, 32'hDEADBEEF, 9'h010, 2'd2});
        end
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        logic [3:0]        eg;
        do_reset();
        set_port(0, 1'b1, 9'h001, 32'hA0A0A0A0);
        set_port(1, 1'b1, 9'h002, 32'hB1B1B1B1);
        for (int i = 0; i < 4; i++) begin
            eg = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            ea = (i % 2 == 1) ? 9'h002 : 9'h001;
            ed = (i % 2 == 1) ? 32'hB1B1B1B1 : 32'hA0A0A0A0;
            #1;
            n_vec++;
            if (gnt() !== eg) begin
                n_err++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt(), eg);
            end
            tick();
            n_vec++;
            if (b0() !== {1'b1, 1'b1, ea, ed, ea, 1'b0, eg[1]}) begin
                n_err++; $display("FAIL rr_bank0[%0d]: got %h expected %h", i, b0(),
                                  {1'b1, 1'b1, ea, ed, ea, 1'b0, eg[1]});
            end
        end
        idle_all();
    endtask

    task automatic test_collision();
        set_port(0, 1'b1, 9'h055, 32'h11110000);
        set_port(2, 1'b1, 9'h055, 32'h22220002);
        set_port(3, 1'b1, 9'h055, 32'h33330003);
        #1;
        n_vec++;
        if (gnt() !== 4'b1000) begin
            n_err++; $display("FAIL col_gnt3: got %b expected %b", gnt(), 4'b1000);
        end
        tick();
        n_vec++;
        if ({b2(), bank_we_1, bank_we_0} !== {1'b1, 1'b1, 9'h055, 32'h33330003, 9'h055, 2'd3, 2'b00}) begin
            n_err++; $display("FAIL col_wr3: got %h expected %h", {b2(), bank_we_1, bank_we_0},
                              {1'b1, 1'b1, 9'h055, 32'h33330003, 9'h055, 2'd3, 2'b00});
        end
        set_port(3, 1'b0, 9'h055, 32'h33330003);
        #1;
        n_vec++;
        if (gnt() !== 4'b0100) begin
            n_err++; $display("FAIL col_gnt2: got %b expected %b", gnt(), 4'b0100);
        end
        tick();
        n_vec++;
        if ({b1(), bank_we_2, bank_we_0} !== {1'b1, 1'b1, 9'h055, 32'h22220002, 9'h055, 2'd2, 2'b00}) begin
            n_err++; $display("FAIL col_wr2: got %h expected %h", {b1(), bank_we_2, bank_we_0},
                              {1'b1, 1'b1, 9'h055, 32'h22220002, 9'h055, 2'd2, 2'b00});
        end
        set_port(2, 1'b0, 9'h055, 32'h22220002);
        #1;
        n_vec++;
        if (gnt() !== 4'b0001) begin
            n_err++; $display("FAIL col_gnt0: got %b expected %b", gnt(), 4'b0001);
        end
        tick();
        n_vec++;
        if ({b0(), bank_we_2, bank_we_1} !== {1'b1, 1'b1, 9'h055, 32'h11110000, 9'h055, 2'd0, 2'b00}) begin
            n_err++; $display("FAIL col_wr0: got %h expected %h", {b0(), bank_we_2, bank_we_1},
                              {1'b1, 1'b1, 9'h055, 32'h11110000, 9'h055, 2'd0, 2'b00});
        end
        idle_all();
    endtask

    task automatic test_priority_mix();
        do_reset();
        // Port-0 candidate blocked by port 2; last winner must stay unchanged.
        set_port(0, 1'b1, 9'h0A0, 32'h000000A0);
        set_port(1, 1'b1, 9'h0A1, 32'h000000A1);
        set_port(2, 1'b1, 9'h0A0, 32'h200000A0);
        set_port(3, 1'b1, 9'h1FF, 32'h300001FF);
        #1;
        n_vec++;
        if (gnt() !== 4'b1100) begin
            n_err++; $display("FAIL mix_block_gnt: got %b expected %b", gnt(), 4'b1100);
        end
        tick();
        n_vec++;
        if ({bank_we_2, bank_we_1, bank_we_0} !== 3'b110) begin
            n_err++; $display("FAIL mix_block_we: got %b expected %b",
                              {bank_we_2, bank_we_1, bank_we_0}, 3'b110);
        end
        wr_req_2 = 1'b0;
        wr_req_3 = 1'b0;
        #1;
        n_vec++;
        if (gnt() !== 4'b0001) begin
            n_err++; $display("FAIL mix_retry_gnt: got %b expected %b", gnt(), 4'b0001);
        end
        tick();
        n_vec++;
        if (gnt() !== 4'b0010) begin
            n_err++; $display("FAIL mix_rr_gnt: got %b expected %b", gnt(), 4'b0010);
        end
        tick();
        set_port(2, 1'b1, 9'h1FF, 32'h200001FF);
        set_port(3, 1'b1, 9'h1FF, 32'h300001FF);
        #1;
        n_vec++;
        if (gnt() !== 4'b1001) begin
            n_err++; $display("FAIL mix_p3p2_gnt: got %b expected %b", gnt(), 4'b1001);
        end
        tick();
        n_vec++;
        if ({bank_we_2, bank_we_1, bank_we_0, lvt_val_0} !== {3'b101, 2'd0}) begin
            n_err++; $display("FAIL mix_p3p2_we: got %b expected %b",
                              {bank_we_2, bank_we_1, bank_we_0, lvt_val_0}, {3'b101, 2'd0});
        end
        idle_all();
    endtask

    task automatic test_back_to_back();
        logic [53:0] exp_b2;
        for (int i = 0; i < 4; i++) begin
            set_port(3, 1'b1, 9'h100 + 9'(i), 32'hC0DE0000 + 32'(i));
            #1;
            n_vec++;
            if (gnt() !== 4'b1000) begin
                n_err++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", i, gnt(), 4'b1000);
            end
            tick();
            exp_b2 = {1'b1, 1'b1, 9'h100 + 9'(i), 32'hC0DE0000 + 32'(i), 9'h100 + 9'(i), 2'd3};
            n_vec++;
            if (b2() !== exp_b2) begin
                n_err++; $display("FAIL b2b_bank2[%0d]: got %h expected %h", i, b2(), exp_b2);
            end
        end
        // Address/data moving with the request low must not reach the bank.
        set_port(3, 1'b0, 9'h0FF, 32'hFFFFFFFF);
        tick();
        n_vec++;
        if (b2() !== {1'b0, 1'b0, 9'h103, 32'hC0DE0003, 9'h103, 2'd3}) begin
            n_err++; $display("FAIL b2b_ignore: got %h expected %h", b2(),
                              {1'b0, 1'b0, 9'h103, 32'hC0DE0003, 9'h103, 2'd3});
        end
    endtask

    task automatic test_reset_mid();
        set_port(3, 1'b1, 9'h0AA, 32'h5A5A5A5A);
        #1;
        n_vec++;
        if (gnt() !== 4'b1000) begin
            n_err++; $display("FAIL rmid_pre_gnt: got %b expected %b", gnt(), 4'b1000);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({gnt(), b0(), b1(), b2()} !== '0) begin
            n_err++; $display("FAIL rmid_low: got %h expected 0", {gnt(), b0(), b1(), b2()});
        end
        tick();
        n_vec++;
        if (b2() !== '0) begin
            n_err++; $display("FAIL rmid_edge: got %h expected 0", b2());
        end
        set_port(3, 1'b0, 9'h0AA, 32'h5A5A5A5A);
        reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({bank_we_2, lvt_we_2} !== 2'b00) begin
                n_err++; $display("FAIL rmid_after[%0d]: got %b expected %b", i,
                                  {bank_we_2, lvt_we_2}, 2'b00);
            end
        end
    endtask

`ifdef LVT_ARB_PERF_EN
    task automatic test_perf();
        do_reset();
        set_port(0, 1'b1, 9'h011, 32'h0);
        set_port(1, 1'b1, 9'h022, 32'h1);
        set_port(3, 1'b1, 9'h022, 32'h3);
        repeat (3) tick();
        wr_req_0 = 1'b0;
        n_vec++;
        if ({stall_cnt_1, stall_cnt_0} !== {16'd3, 16'd2}) begin
            n_err++; $display("FAIL perf_count: got %h expected %h",
                              {stall_cnt_1, stall_cnt_0}, {16'd3, 16'd2});
        end
        repeat (70000) @(posedge clk);
        #1;
        n_vec++;
        if (stall_cnt_1 !== 16'hFFFF) begin
            n_err++; $display("FAIL perf_sat: got %h expected %h", stall_cnt_1, 16'hFFFF);
        end
        idle_all();
    endtask
`endif

    initial begin
        test_reset();
        test_single_port2();
        test_round_robin();
        test_collision();
        test_priority_mix();
        test_back_to_back();
        test_reset_mid();
`ifdef LVT_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
